// File: rtl/vga_timing_pattern.sv
// rtl/vga_timing_pattern.sv - 800x600@60Hz video timing with selectable 12-bit test patterns
//
// Ports:
//   clk          in   pixel clock (40 MHz), sole clock domain
//   rst_n        in   asynchronous active-low reset
//   pattern_sel  in   [1:0] pattern select, asynchronous source
//   hs, vs       out  horizontal / vertical sync, active level SYNC_POL
//   de           out  data enable, high in the visible region
//   r, g, b      out  [3:0] each, pixel colour (zero while de=0)
//   x            out  [10:0] horizontal counter of the current output pixel
//   y            out  [9:0]  vertical counter of the current output pixel
//   frame_start  out  one-cycle pulse aligned with pixel (0,0)
// Every output is registered from the same counter state, so all are mutually aligned.
module vga_timing_pattern #(
    parameter int   H_ACTIVE = 800,
    parameter int   H_FP     = 40,
    parameter int   H_SYNC   = 128,
    parameter int   H_BP     = 88,
    parameter int   V_ACTIVE = 600,
    parameter int   V_FP     = 1,
    parameter int   V_SYNC   = 4,
    parameter int   V_BP     = 23,
    parameter logic SYNC_POL = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  pattern_sel,
    output logic        hs,
    output logic        vs,
    output logic        de,
    output logic [3:0]  r,
    output logic [3:0]  g,
    output logic [3:0]  b,
    output logic [10:0] x,
    output logic [9:0]  y,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic [10:0] h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic [1:0]  sync1_q, sync2_q;
    logic [1:0]  pat_q, pat_d;

    logic        hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d;
    logic [11:0] rgb_q, rgb_d;
    logic [10:0] x_q;
    logic [9:0]  y_q;

    // Colour bars: eight 100-pixel bars decoded with a comparator chain.
    function automatic logic [11:0] bar_colour(input logic [10:0] xx);
        logic [11:0] c;
        if      (xx < 11'd100) c = 12'hFFF;
        else if (xx < 11'd200) c = 12'hFF0;
        else if (xx < 11'd300) c = 12'h0FF;
        else if (xx < 11'd400) c = 12'h0F0;
        else if (xx < 11'd500) c = 12'hF0F;
        else if (xx < 11'd600) c = 12'hF00;
        else if (xx < 11'd700) c = 12'h00F;
        else                   c = 12'h000;
        return c;
    endfunction

    logic        h_last, v_last, at_origin;
    logic        active, hsync_on, vsync_on, on_border;
    logic [1:0]  pat_eff;
    logic [11:0] pix;

    always_comb begin
        h_last    = (h_cnt_q == 11'(H_TOTAL - 1));
        v_last    = (v_cnt_q == 10'(V_TOTAL - 1));
        at_origin = (h_cnt_q == 11'd0) && (v_cnt_q == 10'd0);

        h_cnt_d     = h_last ? 11'd0 : h_cnt_q + 11'd1;
        v_cnt_d     = v_cnt_q;
        frame_cnt_d = frame_cnt_q;
        if (h_last) begin
            v_cnt_d = v_last ? 10'd0 : v_cnt_q + 10'd1;
            if (v_last) frame_cnt_d = frame_cnt_q + 8'd1;
        end

        // The new pattern is taken at (0,0) and already colours that pixel,
        // so a whole frame is always drawn with a single pattern.
        pat_eff = at_origin ? sync2_q : pat_q;
        pat_d   = pat_eff;

        active    = (h_cnt_q < 11'(H_ACTIVE)) && (v_cnt_q < 10'(V_ACTIVE));
        hsync_on  = (h_cnt_q >= 11'(H_ACTIVE + H_FP)) &&
                    (h_cnt_q <  11'(H_ACTIVE + H_FP + H_SYNC));
        vsync_on  = (v_cnt_q >= 10'(V_ACTIVE + V_FP)) &&
                    (v_cnt_q <  10'(V_ACTIVE + V_FP + V_SYNC));
        on_border = (h_cnt_q == 11'd0) || (h_cnt_q == 11'(H_ACTIVE - 1)) ||
                    (v_cnt_q == 10'd0) || (v_cnt_q == 10'(V_ACTIVE - 1));

        case (pat_eff)
            2'd0:    pix = bar_colour(h_cnt_q);
            2'd1:    pix = (h_cnt_q[5] ^ v_cnt_q[5]) ? 12'hFFF : 12'h000;
            2'd2:    pix = {h_cnt_q[7:4], v_cnt_q[7:4], frame_cnt_q[5:2]};
            default: pix = on_border ? 12'hFFF : 12'h00F;
        endcase

        hs_d  = hsync_on ? SYNC_POL : ~SYNC_POL;
        vs_d  = vsync_on ? SYNC_POL : ~SYNC_POL;
        de_d  = active;
        rgb_d = active ? pix : 12'h000;
        fs_d  = at_origin;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            frame_cnt_q <= '0;
            sync1_q     <= '0;
            sync2_q     <= '0;
            pat_q       <= '0;
            hs_q        <= ~SYNC_POL;
            vs_q        <= ~SYNC_POL;
            de_q        <= 1'b0;
            rgb_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            fs_q        <= 1'b0;
        end else begin
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            sync1_q     <= pattern_sel;
            sync2_q     <= sync1_q;
            pat_q       <= pat_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            de_q        <= de_d;
            rgb_q       <= rgb_d;
            x_q         <= h_cnt_q;
            y_q         <= v_cnt_q;
            fs_q        <= fs_d;
        end
    end

    assign hs          = hs_q;
    assign vs          = vs_q;
    assign de          = de_q;
    assign r           = rgb_q[11:8];
    assign g           = rgb_q[7:4];
    assign b           = rgb_q[3:0];
    assign x           = x_q;
    assign y           = y_q;
    assign frame_start = fs_q;

endmodule

// File: doc/vga_timing_pattern.md
# vga_timing_pattern

Generates 800x600@60Hz video timing and a selectable 12-bit RGB test pattern for the 12-bit DVI PMOD output stage. Runs on the 40 MHz pixel clock. Drives the pixel, HS, VS and DE pins directly. All outputs are registered and mutually aligned, so the top level only wires them to the PMOD pins and forwards the pixel clock to CK.

## Interface
Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (pixels)
- H_SYNC, 128, horizontal sync width (pixels)
- H_BP, 88, horizontal back porch (pixels)
- V_ACTIVE, 600, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vertical sync width (lines)
- V_BP, 23, vertical back porch (lines)
- SYNC_POL, 1, active level of hs/vs (1 = positive pulses)

Ports:
- clk  in  1  40 MHz pixel clock; one clock domain, no other clocks
- rst_n  in  1  asynchronous, active-low reset
- pattern_sel  in  2  pattern select; asynchronous source (buttons)
- hs  out  1  horizontal sync
- vs  out  1  vertical sync
- de  out  1  data enable (visible region)
- r, g, b  out  4 each  pixel colour
- x  out  11  horizontal counter of the current output pixel
- y  out  10  vertical counter of the current output pixel
- frame_start  out  1  one-cycle pulse aligned with pixel (0,0)

## Operation
- Counters:
  - h_cnt counts 0..H_TOTAL-1 and wraps to 0 (H_TOTAL = sum of H params = 1056).
  - v_cnt advances when h_cnt wraps and counts 0..V_TOTAL-1 (V_TOTAL = 628).
  - v_cnt wraps to 0 on the same cycle h_cnt wraps from the last line.
- Region decode (per counter values):
  - active = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
  - hsync active when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, i.e. 840..967.
  - vsync active when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, i.e. 601..604, for the whole line.
  - hs/vs = SYNC_POL when the sync is active, else ~SYNC_POL.
- Pattern select:
  - pattern_sel passes through a 2-flop synchroniser.
  - The synchronised value is latched into pat only when h_cnt==0 && v_cnt==0. Mid-frame changes never tear the image.
- frame_cnt: 8-bit counter, increments at each frame wrap, wraps 255->0.
- Patterns (x = h_cnt, y = v_cnt):
  - 0, colour bars: bar k = x/100, implemented as a comparator chain with no divider. Colours for k=0..7: FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
  - 1, checkerboard: (x[5]^y[5]) ? FFF : 000.
  - 2, gradient: r=x[7:4], g=y[7:4], b=frame_cnt[5:2].
  - 3, border: x==0, x==H_ACTIVE-1, y==0 or y==V_ACTIVE-1 gives FFF; otherwise 00F.
- Blanking: r/g/b forced to 0 whenever de=0.
- Reset (asynchronous, on rst_n low):
  - h_cnt, v_cnt, frame_cnt, pat and synchroniser flops = 0.
  - Outputs: hs=vs=~SYNC_POL, de=0, rgb=0, x=0, y=0, frame_start=0.
  - Counting resumes at (0,0) on the first clk edge after rst_n rises.

## Timing
- Fixed latency of 1 clk from the counter state to all outputs. hs, vs, de, rgb, x, y and frame_start are all registered from the same counter state and are therefore always mutually aligned.
- Line = 1056 clk; frame = 1056*628 = 663168 clk, which is 60.3 Hz at 40 MHz.
- frame_start is high exactly 1 clk per frame, on the same cycle as de=1 with x=0, y=0.
- pattern_sel change to a new pattern taking effect:
  - earliest: 2 clk of synchroniser plus the wait to the next (0,0) counter state;
  - latest: one full frame after that.
- Reset asserted mid-frame: outputs go to reset values immediately, without waiting for clk. There is no partial-line recovery; the next frame starts cleanly at (0,0).

## Test plan
- Reset: hold rst_n=0 for 5 clk -> hs=vs=0, de=0, rgb=000, frame_start=0. Release -> first frame_start 1 clk after the first counting edge.
- Horizontal timing: measure over 3 lines -> hs period 1056 clk and high for 128 clk. The rising edge of hs is 840 clk after the rise of de, and de is high for 800 clk per line.
- Vertical timing and frame: -> vs high for exactly 4224 clk starting at line 601. frame_start spacing is 663168 clk. Count of de=1 cycles per frame = 480000.
- Colour bars (pattern_sel=0): -> pixel (150,10)=FF0, (799,0)=000, (0,599)=FFF. During blanking (x=900) rgb=000.
- Pattern switch: change pattern_sel 0->1 at line 300 -> the rest of that frame is still bars. The next frame is checkerboard: (0,0)=000, (32,0)=FFF, (32,32)=000.
- Reset mid-frame: assert rst_n low at line 250, pixel 400 (combinational check before the next clk) -> outputs reset immediately. After release, frame timing restarts from (0,0) and the next frame_start arrives 663168 clk after the first one.
